aes_pin_serdes: RTL and testbench

AES_PIN_SERDES -- requirements
Module: aes_pin_serdes

---
 rtl/aes_pkg.sv | 23 ++
 rtl/aes_piso.sv | 60 ++++++
 rtl/aes_pin_serdes.sv | 162 ++++++++++++++++
 tb/tb_aes_pin_serdes.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES pin serializer/deserializer.
//   - default block/key/result width and pin slice widths
//   - controller state type
//   - cnt_w(): counter width for a beat count, never narrower than one bit
package aes_pkg;

    localparam int AES_DATA_W = 128;
    localparam int AES_IN_W   = 4;
    localparam int AES_OUT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // A single-beat transfer still needs a one-bit counter to stay legal.
    function automatic int cnt_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/aes_piso.sv
// Parallel-in / serial-out drain register for the result path.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   load       - capture load_data and restart the beat count
//   load_data  - DATA_W-wide word to serialize
//   shift      - advance one OUT_W slice (ignored when load is high)
//   slice      - current MSB-side slice of the register
//   last       - the slice currently presented is the final one
module aes_piso
    import aes_pkg::*;
#(
    parameter int DATA_W = AES_DATA_W,
    parameter int OUT_W  = AES_OUT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              shift,
    output logic [OUT_W-1:0]  slice,
    output logic              last
);

    localparam int BEATS = DATA_W / OUT_W;
    localparam int CW    = cnt_w(BEATS);

    logic [DATA_W-1:0] data_reg;
    logic [DATA_W-1:0] data_shifted;
    logic [CW-1:0]     cnt_reg;

    // Each OUT_W slot takes the contents of the slot below it; the bottom
    // slot fills with zeros so nothing stale re-emerges after the drain.
    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_slot
            if (gi == 0) begin : g_fill
                assign data_shifted[OUT_W-1:0] = '0;
            end else begin : g_move
                assign data_shifted[gi*OUT_W +: OUT_W] = data_reg[(gi-1)*OUT_W +: OUT_W];
            end
        end
    endgenerate

    assign slice = data_reg[DATA_W-1 -: OUT_W];
    assign last  = (cnt_reg == CW'(BEATS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg <= '0;
            cnt_reg  <= '0;
        end else if (load) begin
            data_reg <= load_data;
            cnt_reg  <= '0;
        end else if (shift) begin
            data_reg <= data_shifted;
            cnt_reg  <= last ? '0 : cnt_reg + CW'(1);
        end
    end

endmodule

// File: rtl/aes_pin_serdes.sv
// Narrow-pin front end for an AES core: deserializes block and key from
// IN_W-wide pins, starts the core, then serializes the result on OUT_W pins.
// A loopback mode (test=1 on the final load beat) returns block XOR key
// without involving the core.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   en, test                  - load strobe, loopback select
//   block_i, key_i            - IN_W input slices, MSB first
//   core_block_o, core_key_o  - assembled operands to the core
//   core_start_o              - one-cycle start pulse to the core
//   core_done_i, core_result_i- core completion pulse and result
//   result_o, done_o, last_o  - OUT_W result slice, valid, final beat
//   busy_o                    - controller not idle
module aes_pin_serdes
    import aes_pkg::*;
#(
    parameter int DATA_W = AES_DATA_W,
    parameter int IN_W   = AES_IN_W,
    parameter int OUT_W  = AES_OUT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              test,
    input  logic [IN_W-1:0]   block_i,
    input  logic [IN_W-1:0]   key_i,
    output logic [DATA_W-1:0] core_block_o,
    output logic [DATA_W-1:0] core_key_o,
    output logic              core_start_o,
    input  logic              core_done_i,
    input  logic [DATA_W-1:0] core_result_i,
    output logic [OUT_W-1:0]  result_o,
    output logic              done_o,
    output logic              last_o,
    output logic              busy_o
);

    localparam int LBEATS = DATA_W / IN_W;
    localparam int LCW    = cnt_w(LBEATS);

    generate
        if (IN_W < 1 || OUT_W < 1 || (DATA_W % IN_W) != 0 || (DATA_W % OUT_W) != 0) begin : g_param_check
            $error("aes_pin_serdes: DATA_W must be a multiple of IN_W and OUT_W, both >= 1");
        end
    endgenerate

    state_t            state_reg, state_next;
    logic [LCW-1:0]    lcnt_reg;
    logic [DATA_W-1:0] core_block_reg, core_key_reg;
    logic [DATA_W-1:0] block_shift, key_shift;
    logic              start_reg, start_next;

    logic              load_beat;
    logic              load_last;

    logic              piso_load;
    logic              piso_shift;
    logic [DATA_W-1:0] piso_data;
    logic [OUT_W-1:0]  piso_slice;
    logic              piso_last;

    // Shift the operand registers up by one IN_W slot with the new pin slice
    // entering at the bottom; after LBEATS beats beat 0 sits in the MSBs.
    genvar gi;
    generate
        for (gi = 0; gi < LBEATS; gi++) begin : g_shift
            if (gi == 0) begin : g_in
                assign block_shift[IN_W-1:0] = block_i;
                assign key_shift[IN_W-1:0]   = key_i;
            end else begin : g_move
                assign block_shift[gi*IN_W +: IN_W] = core_block_reg[(gi-1)*IN_W +: IN_W];
                assign key_shift[gi*IN_W +: IN_W]   = core_key_reg[(gi-1)*IN_W +: IN_W];
            end
        end
    endgenerate

    // Loading is only possible from IDLE or LOAD, so operands are frozen
    // throughout RUN and DRAIN without any extra hold logic.
    assign load_beat = en && (state_reg == IDLE || state_reg == LOAD);
    assign load_last = load_beat && (lcnt_reg == LCW'(LBEATS - 1));

    always_comb begin
        state_next = state_reg;
        start_next = 1'b0;
        piso_load  = 1'b0;
        piso_shift = 1'b0;
        piso_data  = core_result_i;

        case (state_reg)
            IDLE, LOAD: begin
                if (load_beat) begin
                    if (load_last) begin
                        if (test) begin
                            // Use the shifted values so the final beat is included.
                            piso_load  = 1'b1;
                            piso_data  = block_shift ^ key_shift;
                            state_next = DRAIN;
                        end else begin
                            start_next = 1'b1;
                            state_next = RUN;
                        end
                    end else begin
                        state_next = LOAD;
                    end
                end
            end
            RUN: begin
                if (core_done_i) begin
                    piso_load  = 1'b1;
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                piso_shift = 1'b1;
                if (piso_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            lcnt_reg       <= '0;
            core_block_reg <= '0;
            core_key_reg   <= '0;
            start_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            start_reg <= start_next;
            if (load_beat) begin
                core_block_reg <= block_shift;
                core_key_reg   <= key_shift;
                lcnt_reg       <= load_last ? '0 : lcnt_reg + LCW'(1);
            end
        end
    end

    aes_piso #(
        .DATA_W (DATA_W),
        .OUT_W  (OUT_W)
    ) u_piso (
        .clk       (clk),
        .rst       (rst),
        .load      (piso_load),
        .load_data (piso_data),
        .shift     (piso_shift),
        .slice     (piso_slice),
        .last      (piso_last)
    );

    assign core_block_o = core_block_reg;
    assign core_key_o   = core_key_reg;
    assign core_start_o = start_reg;
    assign done_o       = (state_reg == DRAIN);
    assign last_o       = done_o && piso_last;
    assign result_o     = done_o ? piso_slice : '0;
    assign busy_o       = (state_reg != IDLE);

endmodule

// File: tb/tb_aes_pin_serdes.sv
// Self-checking bench for aes_pin_serdes: default instance (4-bit in, 8-bit
// out) plus an 8-bit in / 16-bit out instance. Expected values come from a
// word-level model: operands are the loaded words, the result is block^key
// in loopback or the core model's value otherwise, drained MSB slice first.
module tb_aes_pin_serdes;

    logic         clk = 1'b0;
    logic         rst;
    logic         test;
    logic         core_done_i;
    logic [127:0] core_result_i;

    logic         sel;
    logic         drv_en;
    logic [7:0]   drv_blk, drv_key;

    logic         en_a, en_b;
    logic [3:0]   block_a, key_a;
    logic [7:0]   block_b, key_b;
    logic [127:0] cb_a, ck_a, cb_b, ck_b;
    logic         start_a, start_b, done_a, done_b, last_a, last_b, busy_a, busy_b;
    logic [7:0]   result_a;
    logic [15:0]  result_b;

    logic [127:0] cur_cb, cur_ck;
    logic         cur_start, cur_done, cur_last, cur_busy;
    logic [15:0]  cur_result;

    int total = 0;
    int bad   = 0;
    int cyc;

    // results of collect()
    int           n_start, start_cyc, first_done, last_done, n_last;
    int           zero_viol, stable_viol, busy_after, timed_out;
    logic [127:0] cb_at_start, ck_at_start;
    logic [15:0]  beats[$];

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_BLK = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_RES = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    always #5 clk = ~clk;

    always_comb begin
        en_a    = sel ? 1'b0 : drv_en;
        en_b    = sel ? drv_en : 1'b0;
        block_a = drv_blk[3:0];
        key_a   = drv_key[3:0];
        block_b = drv_blk;
        key_b   = drv_key;
        cur_cb     = sel ? cb_b : cb_a;
        cur_ck     = sel ? ck_b : ck_a;
        cur_start  = sel ? start_b : start_a;
        cur_done   = sel ? done_b : done_a;
        cur_last   = sel ? last_b : last_a;
        cur_busy   = sel ? busy_b : busy_a;
        cur_result = sel ? result_b : {8'h00, result_a};
    end

    aes_pin_serdes u_dut (
        .clk(clk), .rst(rst), .en(en_a), .test(test),
        .block_i(block_a), .key_i(key_a),
        .core_block_o(cb_a), .core_key_o(ck_a), .core_start_o(start_a),
        .core_done_i(core_done_i), .core_result_i(core_result_i),
        .result_o(result_a), .done_o(done_a), .last_o(last_a), .busy_o(busy_a)
    );

    aes_pin_serdes #(.DATA_W(128), .IN_W(8), .OUT_W(16)) u_dut_wide (
        .clk(clk), .rst(rst), .en(en_b), .test(test),
        .block_i(block_b), .key_i(key_b),
        .core_block_o(cb_b), .core_key_o(ck_b), .core_start_o(start_b),
        .core_done_i(core_done_i), .core_result_i(core_result_i),
        .result_o(result_b), .done_o(done_b), .last_o(last_b), .busy_o(busy_b)
    );

    function automatic logic [15:0] exp_beat(input logic [127:0] v, input int ow, input int k);
        logic [127:0] t;
        t = v >> (128 - ow * (k + 1));
        return (ow == 16) ? t[15:0] : {8'h00, t[7:0]};
    endfunction

    function automatic logic [7:0] in_slice(input logic [127:0] v, input int iw, input int b);
        logic [127:0] t;
        t = v >> (128 - iw * (b + 1));
        return (iw == 8) ? t[7:0] : {4'h0, t[3:0]};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drives nb load beats; pauses en for 3 cycles after beats p0 and p1.
    task automatic load_beats(input logic [127:0] blk, input logic [127:0] key,
                              input logic tst, input int p0, input int p1, input int nb);
        int iw;
        iw  = sel ? 8 : 4;
        cyc = 0;
        for (int b = 0; b < nb; b++) begin
            drv_en  = 1'b1;
            drv_blk = in_slice(blk, iw, b);
            drv_key = in_slice(key, iw, b);
            test    = tst;
            @(negedge clk); cyc++;
            if (b == p0 || b == p1) begin
                drv_en = 1'b0;
                for (int w = 0; w < 3; w++) begin
                    drv_blk = 8'($urandom);
                    drv_key = 8'($urandom);
                    test    = 1'($urandom);
                    @(negedge clk); cyc++;
                end
            end
        end
        drv_en  = 1'b0;
        drv_blk = 8'($urandom);
        drv_key = 8'($urandom);
        test    = 1'($urandom);
    endtask

    // Core model plus result collector; noise adds ignored en/core_done_i activity.
    task automatic collect(input logic [127:0] res, input int delay, input bit noise);
        int cd;
        int post;
        bit fin;
        cd = 0; post = 0; fin = 0;
        n_start = 0; start_cyc = -1; first_done = -1; last_done = -1; n_last = 0;
        zero_viol = 0; stable_viol = 0; busy_after = -1; timed_out = 1;
        beats.delete();
        for (int i = 0; i < 400; i++) begin
            if (cur_start) begin
                n_start++;
                if (n_start == 1) begin
                    start_cyc = cyc; cb_at_start = cur_cb; ck_at_start = cur_ck; cd = delay;
                end
            end else if (n_start > 0 && cur_busy && (cur_cb !== cb_at_start || cur_ck !== ck_at_start)) begin
                stable_viol++;
            end
            if (cur_done) begin
                beats.push_back(cur_result);
                if (first_done < 0) first_done = cyc;
                last_done = cyc;
                if (cur_last) n_last++;
            end else if (cur_result !== 16'h0) begin
                zero_viol++;
            end
            if (fin) begin
                if (post == 0) busy_after = cur_busy;
                post++;
                if (post == 4) begin timed_out = 0; break; end
            end
            if (cur_done && cur_last) fin = 1;

            core_done_i   = 1'b0;
            core_result_i = rand128();
            drv_en        = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin core_done_i = 1'b1; core_result_i = res; end
            end
            if (noise && post == 0) begin
                if (cur_busy) drv_en = 1'($urandom);
                if (cur_done) core_done_i = 1'b1;
                if (cur_done && cur_last) drv_en = 1'b1;
            end
            drv_blk = 8'($urandom);
            drv_key = 8'($urandom);
            test    = 1'($urandom);
            @(negedge clk); cyc++;
        end
        core_done_i = 1'b0;
        drv_en      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (busy_a !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b want=0", busy_a); end
        total++; if (done_a !== 1'b0)  begin bad++; $display("FAIL reset_done got=%b want=0", done_a); end
        total++; if (last_a !== 1'b0)  begin bad++; $display("FAIL reset_last got=%b want=0", last_a); end
        total++; if (start_a !== 1'b0) begin bad++; $display("FAIL reset_start got=%b want=0", start_a); end
        total++; if (result_a !== 8'h0) begin bad++; $display("FAIL reset_result got=%h want=0", result_a); end
        total++; if (cb_a !== 128'h0 || ck_a !== 128'h0) begin bad++; $display("FAIL reset_operands block=%h key=%h want=0", cb_a, ck_a); end
        total++; if (busy_b !== 1'b0 || result_b !== 16'h0) begin bad++; $display("FAIL reset_wide busy=%b result=%h want=0", busy_b, result_b); end
        rst = 1'b0;
        @(negedge clk);
        $display("test_reset: done");
    endtask

    task automatic check_stream(input string name, input logic [127:0] exp, input int ow,
                                input int exp_starts, input int exp_first);
        int nb;
        nb = 128 / ow;
        total++; if (timed_out != 0) begin bad++; $display("FAIL %s_timeout got=%0d want=0", name, timed_out); end
        total++; if (n_start != exp_starts) begin bad++; $display("FAIL %s_starts got=%0d want=%0d", name, n_start, exp_starts); end
        total++; if (beats.size() != nb) begin bad++; $display("FAIL %s_beat_count got=%0d want=%0d", name, beats.size(), nb); end
        for (int k = 0; k < nb; k++) begin
            total++;
            if (k >= beats.size() || beats[k] !== exp_beat(exp, ow, k)) begin
                bad++;
                $display("FAIL %s_beat%0d got=%h want=%h", name, k, (k < beats.size()) ? beats[k] : 16'hxxxx, exp_beat(exp, ow, k));
            end
        end
        total++; if (first_done != exp_first) begin bad++; $display("FAIL %s_first_done got=%0d want=%0d", name, first_done, exp_first); end
        total++; if (last_done - first_done != nb - 1) begin bad++; $display("FAIL %s_consecutive got=%0d want=%0d", name, last_done - first_done, nb - 1); end
        total++; if (n_last != 1) begin bad++; $display("FAIL %s_last_count got=%0d want=1", name, n_last); end
        total++; if (zero_viol != 0) begin bad++; $display("FAIL %s_result_not_zero got=%0d want=0", name, zero_viol); end
        total++; if (stable_viol != 0) begin bad++; $display("FAIL %s_operand_stable got=%0d want=0", name, stable_viol); end
        total++; if (busy_after != 0) begin bad++; $display("FAIL %s_idle_after got=%0d want=0", name, busy_after); end
        $display("%s: starts=%0d beats=%0d first_done=%0d", name, n_start, beats.size(), first_done);
    endtask

    task automatic test_fips();
        sel = 1'b0;
        load_beats(FIPS_BLK, FIPS_KEY, 1'b0, -1, -1, 32);
        collect(FIPS_RES, 10, 1'b0);
        total++; if (start_cyc != 32) begin bad++; $display("FAIL fips_start_cycle got=%0d want=32", start_cyc); end
        total++; if (cb_at_start !== FIPS_BLK) begin bad++; $display("FAIL fips_block got=%h want=%h", cb_at_start, FIPS_BLK); end
        total++; if (ck_at_start !== FIPS_KEY) begin bad++; $display("FAIL fips_key got=%h want=%h", ck_at_start, FIPS_KEY); end
        check_stream("fips", FIPS_RES, 8, 1, start_cyc + 10);
    endtask

    task automatic test_loopback();
        logic [127:0] k0f;
        k0f = {16{8'h0F}};
        sel = 1'b0;
        load_beats({128{1'b1}}, k0f, 1'b1, -1, -1, 32);
        collect(rand128(), 10, 1'b0);
        check_stream("loopback", {16{8'hF0}}, 8, 0, 32);
    endtask

    task automatic test_pause();
        sel = 1'b0;
        load_beats(FIPS_BLK, FIPS_KEY, 1'b0, 0, 15, 31);
        // third pause after beat 30, then the final beat
        drv_en = 1'b0;
        repeat (3) begin drv_blk = 8'($urandom); drv_key = 8'($urandom); @(negedge clk); cyc++; end
        drv_en = 1'b1; drv_blk = in_slice(FIPS_BLK, 4, 31); drv_key = in_slice(FIPS_KEY, 4, 31); test = 1'b0;
        @(negedge clk); cyc++;
        drv_en = 1'b0;
        collect(FIPS_RES, 10, 1'b0);
        total++; if (start_cyc != 41) begin bad++; $display("FAIL pause_start_cycle got=%0d want=41", start_cyc); end
        total++; if (cb_at_start !== FIPS_BLK || ck_at_start !== FIPS_KEY) begin bad++; $display("FAIL pause_operands block=%h key=%h", cb_at_start, ck_at_start); end
        check_stream("pause", FIPS_RES, 8, 1, start_cyc + 10);
    endtask

    task automatic test_random();
        sel = 1'b0;
        for (int t = 0; t < 8; t++) begin
            logic [127:0] blk, key, res;
            logic tst;
            int p0, p1, dly, ld;
            blk = rand128(); key = rand128(); res = rand128();
            tst = 1'($urandom);
            p0  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 14)) : -1;
            p1  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(15, 30)) : -1;
            dly = $urandom_range(1, 20);
            ld  = 32 + ((p0 >= 0) ? 3 : 0) + ((p1 >= 0) ? 3 : 0);
            load_beats(blk, key, tst, p0, p1, 32);
            collect(res, dly, 1'b0);
            if (tst) begin
                check_stream("rand_loop", blk ^ key, 8, 0, ld);
            end else begin
                total++; if (start_cyc != ld) begin bad++; $display("FAIL rand_start_cycle got=%0d want=%0d", start_cyc, ld); end
                total++; if (cb_at_start !== blk || ck_at_start !== key) begin bad++; $display("FAIL rand_operands block=%h key=%h want %h %h", cb_at_start, ck_at_start, blk, key); end
                check_stream("rand_core", res, 8, 1, ld + dly);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [127:0] blk, key, res;
        int late_done;
        sel = 1'b0;
        // reset on load beat 20, then a full reload
        load_beats(rand128(), rand128(), 1'b0, -1, -1, 20);
        drv_en = 1'b1; drv_blk = 8'($urandom); drv_key = 8'($urandom); rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; drv_en = 1'b0;
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL abort_load_busy got=%b want=0", busy_a); end
        total++; if (cb_a !== 128'h0 || ck_a !== 128'h0) begin bad++; $display("FAIL abort_load_clear block=%h key=%h want=0", cb_a, ck_a); end
        @(negedge clk);
        blk = rand128(); key = rand128(); res = rand128();
        load_beats(blk, key, 1'b0, -1, -1, 32);
        collect(res, 5, 1'b0);
        total++; if (cb_at_start !== blk || ck_at_start !== key) begin bad++; $display("FAIL reload_operands block=%h key=%h", cb_at_start, ck_at_start); end
        check_stream("reload", res, 8, 1, 37);
        // reset mid-RUN, then a late core_done_i
        load_beats(rand128(), rand128(), 1'b0, -1, -1, 32);
        total++; if (start_a !== 1'b1) begin bad++; $display("FAIL abort_run_start got=%b want=1", start_a); end
        @(negedge clk);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        core_done_i = 1'b1; core_result_i = rand128(); @(negedge clk); core_done_i = 1'b0;
        late_done = 0;
        repeat (20) begin
            if (done_a || busy_a || result_a != 8'h0) late_done++;
            @(negedge clk);
        end
        total++; if (late_done != 0) begin bad++; $display("FAIL abort_run_late_done got=%0d want=0", late_done); end
        $display("test_reset_abort: done");
    endtask

    task automatic test_noise();
        sel = 1'b0;
        core_done_i = 1'b1; core_result_i = rand128();
        @(negedge clk);
        core_done_i = 1'b0;
        total++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin bad++; $display("FAIL idle_done_ignored busy=%b done=%b want=0", busy_a, done_a); end
        load_beats(FIPS_BLK, FIPS_KEY, 1'b0, -1, -1, 32);
        collect(FIPS_RES, 10, 1'b1);
        check_stream("noise", FIPS_RES, 8, 1, start_cyc + 10);
    endtask

    task automatic test_wide();
        sel = 1'b1;
        load_beats(FIPS_BLK, FIPS_KEY, 1'b0, -1, -1, 16);
        collect(FIPS_RES, 10, 1'b0);
        total++; if (start_cyc != 16) begin bad++; $display("FAIL wide_start_cycle got=%0d want=16", start_cyc); end
        total++; if (cb_at_start !== FIPS_BLK || ck_at_start !== FIPS_KEY) begin bad++; $display("FAIL wide_operands block=%h key=%h", cb_at_start, ck_at_start); end
        check_stream("wide", FIPS_RES, 16, 1, start_cyc + 10);
        sel = 1'b0;
    endtask

    initial begin
        rst = 1'b1; test = 1'b0; core_done_i = 1'b0; core_result_i = '0;
        sel = 1'b0; drv_en = 1'b0; drv_blk = '0; drv_key = '0;
        @(negedge clk);
        test_reset();
        test_fips();
        test_loopback();
        test_pause();
        test_random();
        test_reset_abort();
        test_noise();
        test_wide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
